// File: rtl/ras_pred_checker.sv
// rtl/ras_pred_checker.sv - return-address-stack prediction checker
// Queues frontend return predictions, checks them against backend resolves, reports mispredicts.
module ras_pred_checker #(
  parameter int unsigned NR_ENTRIES = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned VLEN       = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 pred_valid_i,
  output logic                 pred_ready_o,
  input  logic [VLEN-1:0]      pred_target_i,
  input  logic                 pred_hit_i,
  input  logic                 resolve_valid_i,
  input  logic [VLEN-1:0]      resolve_target_i,
  output logic                 mispredict_o,
  output logic [VLEN-1:0]      mispredict_target_o,
  output logic                 resolve_err_o,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(NR_ENTRIES);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e state_q, state_d;

  logic [VLEN-1:0]      tgt_q [NR_ENTRIES];
  logic                 hit_q [NR_ENTRIES];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;
  logic                 mispredict_q, resolve_err_q;
  logic [VLEN-1:0]      mis_target_q;

  logic push, push_eff, resolve_run, pop, wrong, err;

  assign push        = pred_valid_i && pred_ready_o && !flush_i;
  assign resolve_run = resolve_valid_i && (state_q == RUN) && !flush_i;
  assign pop         = resolve_run && (count_q != '0);
  assign err         = resolve_run && (count_q == '0);
  assign wrong       = pop && (!hit_q[rptr_q] || (tgt_q[rptr_q] != resolve_target_i));
  // A mispredict makes anything pushed alongside it wrong-path as well.
  assign push_eff    = push && !wrong;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i)    state_d = RUN;
    else if (wrong) state_d = RECOVER;
  end

  // Output decode from registered state only
  always_comb begin
    pred_ready_o = (state_q == RUN) && (count_q != CNT_FULL);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else if (wrong) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + 1'b1;
      if (pop)      rptr_d = rptr_q + 1'b1;
      case ({push_eff, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        tgt_q[i] <= '0;
        hit_q[i] <= 1'b0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) begin
        tgt_q[wptr_q] <= pred_target_i;
        hit_q[wptr_q] <= pred_hit_i;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
      mis_target_q  <= '0;
    end else begin
      mispredict_q  <= wrong;
      resolve_err_q <= err;
      if (wrong) mis_target_q <= resolve_target_i;
      if (pop && !wrong && (hit_cnt_q != '1)) hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (wrong && (miss_cnt_q != '1))        miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign mispredict_o        = mispredict_q;
  assign mispredict_target_o = mis_target_q;
  assign resolve_err_o       = resolve_err_q;
  assign hit_cnt_o           = hit_cnt_q;
  assign miss_cnt_o          = miss_cnt_q;

endmodule

// File: tb/tb_ras_pred_checker.sv
// tb/tb_ras_pred_checker.sv - directed self-checking bench for ras_pred_checker
// Narrow counters so saturation is reachable within a short run.
module tb_ras_pred_checker;

  localparam int VLEN = 64;
  localparam int CW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            pred_valid_i;
  logic            pred_ready_o;
  logic [VLEN-1:0] pred_target_i;
  logic            pred_hit_i;
  logic            resolve_valid_i;
  logic [VLEN-1:0] resolve_target_i;
  logic            mispredict_o;
  logic [VLEN-1:0] mispredict_target_o;
  logic            resolve_err_o;
  logic [CW-1:0]   hit_cnt_o;
  logic [CW-1:0]   miss_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ras_pred_checker #(.NR_ENTRIES(4), .CNT_WIDTH(CW), .VLEN(VLEN)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .pred_valid_i       (pred_valid_i),
    .pred_ready_o       (pred_ready_o),
    .pred_target_i      (pred_target_i),
    .pred_hit_i         (pred_hit_i),
    .resolve_valid_i    (resolve_valid_i),
    .resolve_target_i   (resolve_target_i),
    .mispredict_o       (mispredict_o),
    .mispredict_target_o(mispredict_target_o),
    .resolve_err_o      (resolve_err_o),
    .hit_cnt_o          (hit_cnt_o),
    .miss_cnt_o         (miss_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [VLEN-1:0] t, input logic h);
    pred_valid_i = 1'b1; pred_target_i = t; pred_hit_i = h;
    step();
    pred_valid_i = 1'b0;
  endtask

  task automatic resolve(input logic [VLEN-1:0] t);
    resolve_valid_i = 1'b1; resolve_target_i = t;
    step();
    resolve_valid_i = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int h, input int m);
    chk({tag, "_hit"},  64'(hit_cnt_o),  64'(h));
    chk({tag, "_miss"}, 64'(miss_cnt_o), 64'(m));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(pred_ready_o),  64'd1);
    chk({tag, "_mis"},   64'(mispredict_o),  64'd0);
    chk({tag, "_mtgt"},  mispredict_target_o, 64'd0);
    chk({tag, "_err"},   64'(resolve_err_o), 64'd0);
    chk_cnt(tag, 0, 0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    pred_valid_i = 1'b0; pred_target_i = '0; pred_hit_i = 1'b0;
    resolve_valid_i = 1'b0; resolve_target_i = '0;
    #12;
    chk_reset("reset");
    rst_ni = 1'b1;
    step();

    // Three correct predictions
    push(64'h1000, 1'b1); chk("t1_rdy0", 64'(pred_ready_o), 64'd1);
    push(64'h2000, 1'b1); chk("t1_rdy1", 64'(pred_ready_o), 64'd1);
    push(64'h3000, 1'b1); chk("t1_rdy2", 64'(pred_ready_o), 64'd1);
    resolve(64'h1000); chk("t1_mis0", 64'(mispredict_o), 64'd0);
    resolve(64'h2000); chk("t1_mis1", 64'(mispredict_o), 64'd0);
    resolve(64'h3000); chk("t1_mis2", 64'(mispredict_o), 64'd0);
    chk("t1_err", 64'(resolve_err_o), 64'd0);
    chk("t1_rdy3", 64'(pred_ready_o), 64'd1);
    chk_cnt("t1", 3, 0);

    // Fill, drop, pop while full
    push(64'h100, 1'b1); push(64'h200, 1'b1); push(64'h300, 1'b1); push(64'h400, 1'b1);
    chk("fill_rdy", 64'(pred_ready_o), 64'd0);
    push(64'h500, 1'b1);
    chk("fill_drop_cnt", 64'(dut.count_q), 64'd4);
    pred_valid_i = 1'b1; pred_target_i = 64'h600; pred_hit_i = 1'b1;
    resolve(64'h100);
    pred_valid_i = 1'b0;
    chk("full_pop_cnt", 64'(dut.count_q), 64'd3);
    chk("full_pop_rdy", 64'(pred_ready_o), 64'd1);
    resolve(64'h200); resolve(64'h300); resolve(64'h400);
    chk("fill_mis", 64'(mispredict_o), 64'd0);
    chk("fill_empty", 64'(dut.count_q), 64'd0);
    chk_cnt("fill", 7, 0);

    // Target mismatch
    push(64'h1000, 1'b1); push(64'h2000, 1'b1);
    resolve(64'h1004);
    chk("mm_mis", 64'(mispredict_o), 64'd1);
    chk("mm_tgt", mispredict_target_o, 64'h1004);
    chk("mm_rdy", 64'(pred_ready_o), 64'd0);
    chk("mm_cnt", 64'(dut.count_q), 64'd0);
    chk_cnt("mm", 7, 1);
    step();
    chk("mm_pulse_end", 64'(mispredict_o), 64'd0);
    chk("mm_tgt_hold", mispredict_target_o, 64'h1004);
    resolve(64'h2000);
    chk("rec_mis", 64'(mispredict_o), 64'd0);
    chk("rec_err", 64'(resolve_err_o), 64'd0);
    chk_cnt("rec", 7, 1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("flush_rdy", 64'(pred_ready_o), 64'd1);
    chk("flush_cnt", 64'(dut.count_q), 64'd0);

    // Empty-stack prediction
    push(64'h1000, 1'b0);
    resolve(64'h1000);
    chk("es_mis", 64'(mispredict_o), 64'd1);
    chk("es_tgt", mispredict_target_o, 64'h1000);
    chk_cnt("es", 7, 2);
    flush_i = 1'b1; step(); flush_i = 1'b0;

    // Spurious resolve with same-cycle push
    pred_valid_i = 1'b1; pred_target_i = 64'h2222; pred_hit_i = 1'b1;
    resolve(64'h55);
    pred_valid_i = 1'b0;
    chk("sp_err", 64'(resolve_err_o), 64'd1);
    chk("sp_mis", 64'(mispredict_o), 64'd0);
    chk("sp_cnt", 64'(dut.count_q), 64'd1);
    chk_cnt("sp", 7, 2);
    step();
    chk("sp_err_end", 64'(resolve_err_o), 64'd0);
    resolve(64'h2222);
    chk("sp_hit_after", 64'(mispredict_o), 64'd0);
    chk_cnt("sp2", 8, 2);

    // Saturation
    for (int i = 0; i < 17; i++) begin
      push(64'(32'h8000 + i * 4), 1'b1);
      resolve(64'(32'h8000 + i * 4));
    end
    chk_cnt("sat", 15, 2);

    // Flush with same-cycle mismatching resolve and push
    push(64'h700, 1'b1);
    flush_i = 1'b1; pred_valid_i = 1'b1; pred_target_i = 64'h710; pred_hit_i = 1'b1;
    resolve(64'h999);
    flush_i = 1'b0; pred_valid_i = 1'b0;
    chk("fr_mis", 64'(mispredict_o), 64'd0);
    chk("fr_err", 64'(resolve_err_o), 64'd0);
    chk("fr_cnt", 64'(dut.count_q), 64'd0);
    chk("fr_rdy", 64'(pred_ready_o), 64'd1);
    chk_cnt("fr", 15, 2);

    // Pulse scheduled before a flush survives it
    push(64'h10, 1'b1);
    resolve(64'h11);
    chk("pf_mis", 64'(mispredict_o), 64'd1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("pf_mis_end", 64'(mispredict_o), 64'd0);
    chk("pf_rdy", 64'(pred_ready_o), 64'd1);
    chk_cnt("pf", 15, 3);

    // Asynchronous reset mid-stream
    push(64'h10, 1'b1);
    pred_valid_i = 1'b1; pred_target_i = 64'h20; pred_hit_i = 1'b1;
    resolve_valid_i = 1'b1; resolve_target_i = 64'h77;
    #2 rst_ni = 1'b0;
    #1;
    chk_reset("mid_rst");
    chk("mid_rst_cnt", 64'(dut.count_q), 64'd0);
    pred_valid_i = 1'b0; resolve_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    chk("post_rst_rdy", 64'(pred_ready_o), 64'd1);
    chk("post_rst_mis", 64'(mispredict_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_pred_checker.md
Name: ras_pred_checker

Overview:
- Consumer end of the return-address-stack prediction path.
- Records every return-target prediction the frontend issues, in order, and checks each against the target the backend resolves for that return.
- On a wrong prediction, raises a registered mispredict pulse carrying the correct target, then blocks new predictions until the frontend flushes.
- Keeps saturating hit/miss counters for performance monitoring.

Parameters:
- NR_ENTRIES, 4, maximum in-flight return predictions (power of two, >=2).
- CNT_WIDTH, 32, width of the hit/miss statistic counters.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  frontend flush; clears in-flight predictions and leaves RECOVER.
- pred_valid_i  input  1  frontend issued a return prediction this cycle.
- pred_ready_o  output  1  checker can accept a prediction.
- pred_target_i  input  riscv::VLEN  predicted return address.
- pred_hit_i  input  1  predicted entry's valid bit was set (0 means the stack was empty).
- resolve_valid_i  input  1  backend resolved the oldest outstanding return.
- resolve_target_i  input  riscv::VLEN  actual return target.
- mispredict_o  output  1  one-cycle pulse: oldest prediction was wrong.
- mispredict_target_o  output  riscv::VLEN  correct target; valid with mispredict_o.
- resolve_err_o  output  1  one-cycle pulse: resolve arrived with nothing outstanding.
- hit_cnt_o  output  CNT_WIDTH  correct predictions, saturating.
- miss_cnt_o  output  CNT_WIDTH  mispredictions, saturating.

Behaviour:
- Reset: FIFO empty, state RUN.
  - pred_ready_o=1, mispredict_o=0, mispredict_target_o=0, resolve_err_o=0, hit_cnt_o=0, miss_cnt_o=0.
- Storage: circular FIFO of NR_ENTRIES entries {target, hit}.
  - Read/write pointers are log2(NR_ENTRIES) bits and wrap naturally.
  - Occupancy count is log2(NR_ENTRIES)+1 bits.
- pred_ready_o = (state==RUN) && (count != NR_ENTRIES), decoded from registered state only.
- Push: pred_valid_i && pred_ready_o writes the entry at wptr; wptr+1.
  - pred_valid_i while not ready is dropped silently.
- Resolve in RUN with count>0:
  - Pop the entry at rptr; rptr+1.
  - Mispredict if entry.hit==0 or entry.target != resolve_target_i (full VLEN compare).
  - Correct: hit_cnt+1 (saturate at all ones); no pulse.
  - Wrong: next cycle mispredict_o=1 and mispredict_target_o=resolve_target_i; miss_cnt+1 (saturate).
  - Wrong also moves the state to RECOVER and discards every remaining entry (count=0, rptr=wptr), since those are wrong-path.
- Resolve in RUN with count==0: next cycle resolve_err_o=1; no counter change, no state change.
- Resolve in RECOVER: ignored; no error, no counters.
- Latency: mispredict_o and resolve_err_o are registered, asserted exactly one cycle after the resolve cycle, high for one cycle.
  - mispredict_target_o holds its last value when mispredict_o=0.
- Push and resolve in the same RUN cycle:
  - Both take effect; count is unchanged.
  - If count==0, there is no bypass: the resolve is an error and the push is still written.
  - If full, no push occurs (ready=0) and the pop happens.
  - If the resolve mispredicts, the same-cycle push is discarded too; the FIFO ends empty.
- States:
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN on flush_i.
  - RUN stays RUN on flush_i, with the FIFO cleared.
- flush_i has priority over push and resolve in the same cycle:
  - FIFO cleared, pointers reset to 0, state RUN.
  - Same-cycle push and resolve are ignored; no pulses result from that cycle.
  - Counters are not cleared.
- A pulse already scheduled from the previous cycle still appears during a flush cycle.
- Reset mid-operation clears everything asynchronously, counters included.

Test Plan:
- Three correct predictions: push 0x1000/0x2000/0x3000 (hit=1), resolve same order -> no pulses; hit_cnt=3, miss_cnt=0; pred_ready_o=1 throughout.
- Fill: push NR_ENTRIES=4 entries -> pred_ready_o=0.
  - A 5th push is dropped.
  - Resolve+push in the same cycle while full -> count stays 3 after the pop; the push is not taken.
- Target mismatch: push 0x1000, 0x2000; resolve 0x1004 -> next cycle mispredict_o=1, target 0x1004; miss_cnt=1; pred_ready_o=0.
  - Further resolves produce nothing.
  - flush_i -> pred_ready_o=1, count=0.
- Empty-stack prediction: push 0x1000 with hit=0, resolve 0x1000 -> mispredict_o=1 with target 0x1000.
- Spurious resolve: resolve with FIFO empty (including a same-cycle push) -> resolve_err_o=1 one cycle later; counters unchanged; the pushed entry remains (count=1).
- Saturation/flush/reset: preload via CNT_WIDTH=4 build, 17 correct resolves -> hit_cnt=15.
  - flush_i with a same-cycle resolve -> no pulse, counters kept.
  - rst_ni low mid-stream -> all outputs at reset values.
